seq_frame_tx: RTL
=================

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning payload bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter PRE_LEN, default 3, meaning number of preamble ones per frame (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning a payload is offered on in_data.
REQ-006 The block SHALL have port in_data, input, WIDTH bits, meaning the payload, transmitted MSB first.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a payload this cycle.
REQ-008 The block SHALL have port tx_bit, output, 1 bit, meaning the serial line bit driven to the downstream sequence detector.
REQ-009 The block SHALL have port tx_en, output, 1 bit, meaning tx_bit is part of a frame this cycle.
REQ-010 The block SHALL have port done, output, 1 bit, meaning a single-cycle pulse on the final (gap) cycle of a frame.
REQ-011 The block SHALL have port cs, output, 2 bits, meaning the current FSM state for debug.

Function
REQ-012 The FSM SHALL have states IDLE=2'b00, PRE=2'b01, DATA=2'b10, GAP=2'b11, with cs equal to the state register.
REQ-013 All outputs SHALL be Moore outputs decoded from registered state, counter and shift register only; no input-to-output combinational path except none.
REQ-014 In IDLE: in_ready=1, tx_en=0, tx_bit=0, done=0.
REQ-015 Accept SHALL occur on an edge where in_valid=1 and in_ready=1: in_data latched into a WIDTH-bit shift register, bit counter cleared, next state PRE (or DATA if PRE_LEN=0).
REQ-016 in_ready SHALL be 1 only in IDLE; in_valid in PRE/DATA/GAP SHALL be ignored and in_data SHALL NOT disturb the frame in flight.
REQ-017 In PRE: tx_en=1, tx_bit=1, for exactly PRE_LEN cycles, then DATA with counter cleared.
REQ-018 In DATA: tx_en=1, tx_bit=shift-register MSB; shift left by one (zero fill) each cycle; exactly WIDTH cycles, then GAP.
REQ-019 In GAP: tx_en=1, tx_bit=0, done=1, for exactly one cycle, then IDLE unconditionally.
REQ-020 Frame length SHALL be PRE_LEN+WIDTH+1 cycles; first frame bit appears in the cycle after the accept edge.
REQ-021 Minimum spacing between frames SHALL be one IDLE cycle (back-to-back in_valid accepted on the edge following GAP).
REQ-022 Bit counter SHALL be wide enough for max(PRE_LEN, WIDTH) and SHALL never wrap within a state.

Reset
REQ-023 When rst=1 at a rising edge, the next state SHALL be IDLE, counter 0, shift register 0, regardless of current state or in_valid.
REQ-024 After reset: cs=2'b00, in_ready=1, tx_en=0, tx_bit=0, done=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no done pulse; in_valid on that same edge SHALL NOT be accepted.

Verification
REQ-026 WIDTH=8, PRE_LEN=3, accept 8'hA5 -> tx_bit over 12 cycles = 1,1,1,1,0,1,0,0,1,0,1,0 with tx_en=1; done=1 only on cycle 12; cs 01x3,10x8,11x1.
REQ-027 PRE_LEN=0, WIDTH=4, accept 4'hF -> tx_bit = 1,1,1,1,0; no PRE state; done on cycle 5.
REQ-028 in_valid held high continuously with 8'hFF then 8'h00 -> second payload accepted on the edge after GAP, one IDLE cycle (in_ready=1, tx_en=0) between frames; first frame payload unchanged.
REQ-029 rst pulsed on DATA bit 4 -> next cycle cs=00, tx_en=0, tx_bit=0, no done pulse; new accept works normally.
REQ-030 in_data changed and in_valid toggled during PRE/DATA -> transmitted bits match the originally latched payload, in_ready stays 0 until IDLE.

Source files
------------

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble ones, MSB-first payload, then one gap cycle.
// Every output is decoded from registered state, counter and shift register.
module seq_frame_tx #(
  parameter int WIDTH   = 8,
  parameter int PRE_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_bit,
  output logic             tx_en,
  output logic             done,
  output logic [1:0]       cs
);

  localparam int MAXC  = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
  localparam int CNT_W = $clog2(MAXC + 1);
  // With no preamble PRE is never entered, so its terminal count is unused.
  localparam logic [CNT_W-1:0] PRE_LAST  = (PRE_LEN > 0) ? CNT_W'(PRE_LEN - 1) : '0;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    DATA = 2'b10,
    GAP  = 2'b11
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = (PRE_LEN == 0) ? DATA : PRE;
      PRE:     if (cnt == PRE_LAST) nxt = DATA;
      DATA:    if (cnt == DATA_LAST) nxt = GAP;
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Counter clears on every state exit so each state starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg <= in_data;
            cnt  <= '0;
          end
        end
        PRE: cnt <= (cnt == PRE_LAST) ? '0 : cnt + CNT_W'(1);
        DATA: begin
          sreg <= sreg << 1;
          cnt  <= (cnt == DATA_LAST) ? '0 : cnt + CNT_W'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    tx_en    = 1'b0;
    tx_bit   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      PRE: begin
        tx_en  = 1'b1;
        tx_bit = 1'b1;
      end
      DATA: begin
        tx_en  = 1'b1;
        tx_bit = sreg[WIDTH-1];
      end
      GAP: begin
        tx_en = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cs = state;

endmodule
